seven_segment_capture_encoder: RTL and testbench
================================================

// Module: seven_segment_capture_encoder
// PURPOSE
//  Receiving end of the team's seven-segment display interface: watches a multiplexed
//  display bus (7 segment lines + one-hot digit selects) and encodes lit patterns back to
//  4-bit hex. Debounces each digit, keeps a per-digit value register and emits one
//  change event per new stable digit value over a valid/ready handshake.
//  Used as a scoreboard front-end and to read back display drivers in system test.
// PARAMETERS
//  NUM_DIGITS     4  digits on the multiplexed bus (1..8)
//  STABLE_CYCLES  4  consecutive identical samples needed to accept a digit (>=2)
//  SEG_ACTIVE_LOW 0  1: segment lines are active-low; inverted on the input register
// PORTS
//  clk        in   1              rising-edge clock
//  rst_n      in   1              asynchronous active-low reset
//  seg        in   7              seg[6]=a .. seg[0]=g
//  dig_sel    in   NUM_DIGITS     one-hot active-high digit select; other codes = blank
//  evt_valid  out  1              change event pending
//  evt_ready  in   1              consumer accepts event when evt_valid&&evt_ready
//  evt_idx    out  3              digit index of event
//  evt_hex    out  4              encoded value (0 when evt_err)
//  evt_err    out  1              pattern not in table
//  digits     out  4*NUM_DIGITS   last legal value per digit, digit i at [4i+3:4i]
//  dig_vld    out  NUM_DIGITS     bit i set once digit i has held a legal value
//  ovr_clr    in   1              synchronous clear of overrun
//  overrun    out  1              sticky: an event was dropped
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counter 0, candidate pattern/index 0.
//  Input stage: seg/dig_sel registered once (seg_q, dig_q). All decisions use *_q.
//  Table (a..g, active-high): 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B
//   A=77 b=1F C=4E d=3D E=4F F=47; any other pattern -> err.
//  FSM: IDLE, TRACK, LOCKED. hit = dig_q one-hot && dig_q==cand_idx && seg_q==cand_pat.
//   IDLE: dig_q one-hot -> load cand, cnt=1, TRACK; else stay.
//   TRACK: hit && cnt==STABLE_CYCLES-1 -> commit, LOCKED; hit -> cnt++;
//    other one-hot -> reload cand, cnt=1; not one-hot -> IDLE, cnt=0.
//   LOCKED: hit -> stay (no re-commit); other one-hot -> reload, cnt=1, TRACK;
//    not one-hot -> IDLE.
//  Latency: a pattern held from edge 0 (captured into *_q) commits on edge STABLE_CYCLES;
//   evt_valid is visible after that edge.
//  Commit: legal: if !dig_vld[i] or digits[i]!=value, write digits[i], set dig_vld[i],
//   raise event (err=0); an equal value raises no event. Illegal: digits unchanged,
//   event with evt_err=1, evt_hex=0.
//  Event buffer (1 entry): evt_* hold stable while evt_valid && !evt_ready.
//   Handshake clears evt_valid next edge. A commit in the handshake cycle loads the new
//   event (evt_valid stays 1, no overrun). A commit while full without handshake drops
//   the new event and sets overrun; digits still update.
//  overrun: cleared by ovr_clr; if set and clear coincide, set wins.
//  cnt saturates and never wraps. Asserting rst_n low mid-track or with an event
//   pending discards all state immediately.
// TESTING
//  1 Hold seg=7E, dig_sel=0001 for 6 cyc, evt_ready=1 -> evt_valid after edge 4
//    with idx0 hex0 err0, digits[3:0]=0, dig_vld=0001; exactly one event.
//  2 Sweep all 16 table patterns on digit2, each held 6 cyc -> 16 events with hex 0..F,
//    err=0; then seg=00 -> event err=1, digits[11:8] stays F.
//  3 Glitch: seg=30 for 3 cyc, then 7F, then 30 for 4 cyc, dig_sel=0100 -> one event
//    hex1; no event for 7F.
//  4 Scan 4 digits at 6 cyc/digit showing 1,2,3,4 with evt_ready=0 -> event idx0
//    held stable, overrun=1, digits=16'h4321, dig_vld=1111; ovr_clr -> overrun=0.
//  5 Handshake the same cycle as a new commit -> evt_valid stays 1, new idx/hex, overrun=0.
//  6 Drop rst_n mid-TRACK and with an event pending -> all outputs 0 asynchronously;
//    after release, 4 samples are needed again before a commit.

Source files
------------

// File: rtl/seven_segment_capture_encoder.sv
// Reads back a multiplexed seven-segment bus: debounces each digit, encodes lit
// patterns to hex, keeps per-digit values and reports changes as handshaked events.
//
// state  | meaning
// IDLE   | bus blank or no valid digit select; nothing tracked
// TRACK  | candidate digit/pattern seen, counting identical samples
// LOCKED | candidate committed; waits for the bus to show something else
module seven_segment_capture_encoder #(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [2:0]              evt_idx,
  output logic [3:0]              evt_hex,
  output logic                    evt_err,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   dig_vld,
  input  logic                    ovr_clr,
  output logic                    overrun
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_TERM = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

  state_t                  state;
  logic [6:0]              seg_q;
  logic [NUM_DIGITS-1:0]   dig_q;
  logic [6:0]              cand_pat;
  logic [2:0]              cand_idx;
  logic [CW-1:0]           cnt;

  logic       dig_onehot;
  logic [2:0] dig_idx;
  logic       hit;
  logic       commit;
  logic       cand_legal;
  logic [3:0] cand_hex;
  logic [3:0] cur_hex;
  logic       cur_vld;
  logic       changed;
  logic       new_evt;
  logic       hs;
  logic       drop;

  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h7E:   r = {1'b1, 4'h0};
      7'h30:   r = {1'b1, 4'h1};
      7'h6D:   r = {1'b1, 4'h2};
      7'h79:   r = {1'b1, 4'h3};
      7'h33:   r = {1'b1, 4'h4};
      7'h5B:   r = {1'b1, 4'h5};
      7'h5F:   r = {1'b1, 4'h6};
      7'h70:   r = {1'b1, 4'h7};
      7'h7F:   r = {1'b1, 4'h8};
      7'h7B:   r = {1'b1, 4'h9};
      7'h77:   r = {1'b1, 4'hA};
      7'h1F:   r = {1'b1, 4'hB};
      7'h4E:   r = {1'b1, 4'hC};
      7'h3D:   r = {1'b1, 4'hD};
      7'h4F:   r = {1'b1, 4'hE};
      7'h47:   r = {1'b1, 4'hF};
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '0;
      dig_q <= '0;
    end else begin
      seg_q <= SEG_ACTIVE_LOW ? ~seg : seg;
      dig_q <= dig_sel;
    end
  end

  assign dig_onehot = ($countones(dig_q) == 1);

  always_comb begin
    dig_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (dig_q[i]) dig_idx = 3'(i);
  end

  assign hit    = dig_onehot && (dig_idx == cand_idx) && (seg_q == cand_pat);
  assign commit = (state == TRACK) && hit && (cnt == CNT_TERM);
  assign {cand_legal, cand_hex} = decode(cand_pat);

  always_comb begin
    cur_hex = '0;
    cur_vld = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (cand_idx == 3'(i)) begin
        cur_hex = digits[4*i +: 4];
        cur_vld = dig_vld[i];
      end
  end

  // An illegal pattern always reports; a legal one only when it differs.
  assign changed = commit && cand_legal && (!cur_vld || (cur_hex != cand_hex));
  assign new_evt = changed || (commit && !cand_legal);
  assign hs      = evt_valid && evt_ready;
  assign drop    = new_evt && evt_valid && !hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cand_pat <= '0;
      cand_idx <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dig_onehot) begin
            cand_pat <= seg_q;
            cand_idx <= dig_idx;
            cnt      <= CNT_ONE;
            state    <= TRACK;
          end
        end
        TRACK: begin
          if (hit) begin
            if (cnt == CNT_TERM) state <= LOCKED;
            else if (cnt != '1)  cnt <= cnt + CNT_ONE;
          end else if (dig_onehot) begin
            cand_pat <= seg_q;
            cand_idx <= dig_idx;
            cnt      <= CNT_ONE;
          end else begin
            cnt   <= '0;
            state <= IDLE;
          end
        end
        LOCKED: begin
          if (!hit) begin
            if (dig_onehot) begin
              cand_pat <= seg_q;
              cand_idx <= dig_idx;
              cnt      <= CNT_ONE;
              state    <= TRACK;
            end else begin
              cnt   <= '0;
              state <= IDLE;
            end
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits    <= '0;
      dig_vld   <= '0;
      evt_valid <= 1'b0;
      evt_idx   <= '0;
      evt_hex   <= '0;
      evt_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (changed) begin
        for (int i = 0; i < NUM_DIGITS; i++)
          if (cand_idx == 3'(i)) begin
            digits[4*i +: 4] <= cand_hex;
            dig_vld[i]       <= 1'b1;
          end
      end
      // A slot freed by this cycle's handshake can take the new event directly.
      if (new_evt && (!evt_valid || hs)) begin
        evt_valid <= 1'b1;
        evt_idx   <= cand_idx;
        evt_hex   <= cand_legal ? cand_hex : 4'h0;
        evt_err   <= !cand_legal;
      end else if (hs) begin
        evt_valid <= 1'b0;
      end
      if (drop)         overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seven_segment_capture_encoder.sv
// Directed bench for seven_segment_capture_encoder; expected events are queued by the
// stimulus and checked by an independent monitor on each handshake.
module tb_seven_segment_capture_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg = '0;
  logic [3:0]  dig_sel = '0;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [2:0]  evt_idx;
  logic [3:0]  evt_hex;
  logic        evt_err;
  logic [15:0] digits;
  logic [3:0]  dig_vld;
  logic        ovr_clr = 1'b0;
  logic        overrun;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [6:0] pat_tab [16];

  seven_segment_capture_encoder #(
    .NUM_DIGITS(4), .STABLE_CYCLES(4), .SEG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .dig_sel(dig_sel),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_idx(evt_idx),
    .evt_hex(evt_hex), .evt_err(evt_err), .digits(digits), .dig_vld(dig_vld),
    .ovr_clr(ovr_clr), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] s, input logic [3:0] d, input int n);
    @(negedge clk);
    seg = s;
    dig_sel = d;
    repeat (n) @(posedge clk);
  endtask

  task automatic expect_evt(input logic [2:0] idx, input logic [3:0] hex, input logic err);
    exp_q.push_back({idx, hex, err});
  endtask

  // monitor: every accepted event must match the head of the queue
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_evt: got idx=%0d hex=%0h err=%0b with nothing expected",
                   evt_idx, evt_hex, evt_err);
        end else begin
          e = exp_q.pop_front();
          chk("evt", {24'h0, evt_idx, evt_hex, evt_err}, {24'h0, e});
        end
      end
    end
  end

  initial begin
    pat_tab[0]  = 7'h7E; pat_tab[1]  = 7'h30; pat_tab[2]  = 7'h6D; pat_tab[3]  = 7'h79;
    pat_tab[4]  = 7'h33; pat_tab[5]  = 7'h5B; pat_tab[6]  = 7'h5F; pat_tab[7]  = 7'h70;
    pat_tab[8]  = 7'h7F; pat_tab[9]  = 7'h7B; pat_tab[10] = 7'h77; pat_tab[11] = 7'h1F;
    pat_tab[12] = 7'h4E; pat_tab[13] = 7'h3D; pat_tab[14] = 7'h4F; pat_tab[15] = 7'h47;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {8'h0, evt_valid, evt_idx, evt_hex, evt_err, digits, dig_vld, overrun},
        32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    evt_ready = 1'b1;

    // 1: single digit, latency of four samples
    expect_evt(3'd0, 4'h0, 1'b0);
    @(negedge clk);
    seg = 7'h7E;
    dig_sel = 4'b0001;
    repeat (4) @(posedge clk);
    #1 chk("t1_not_yet", {31'h0, evt_valid}, 32'h0);
    @(posedge clk);
    #1 chk("t1_latency", {31'h0, evt_valid}, 32'h1);
    repeat (2) @(posedge clk);
    drive(7'h00, 4'b0000, 3);
    chk("t1_digit0", {28'h0, digits[3:0]}, 32'h0);
    chk("t1_dig_vld", {28'h0, dig_vld}, 32'h1);
    chk("t1_one_event", exp_q.size(), 0);

    // 2: full table on digit 2, then an illegal pattern
    for (int i = 0; i < 16; i++) begin
      expect_evt(3'd2, 4'(i), 1'b0);
      drive(pat_tab[i], 4'b0100, 6);
    end
    expect_evt(3'd2, 4'h0, 1'b1);
    drive(7'h00, 4'b0100, 6);
    chk("t2_digit2_kept", {28'h0, digits[11:8]}, 32'hF);
    chk("t2_all_events", exp_q.size(), 0);

    // 3: short runs and a one-sample glitch must not commit
    expect_evt(3'd2, 4'h1, 1'b0);
    drive(7'h30, 4'b0100, 3);
    drive(7'h7F, 4'b0100, 1);
    drive(7'h30, 4'b0100, 4);
    drive(7'h00, 4'b0000, 3);
    chk("t3_digit2", {28'h0, digits[11:8]}, 32'h1);
    chk("t3_events", exp_q.size(), 0);

    // 4: scan with consumer stalled
    @(negedge clk);
    evt_ready = 1'b0;
    expect_evt(3'd0, 4'h1, 1'b0);
    drive(7'h30, 4'b0001, 6);
    drive(7'h6D, 4'b0010, 6);
    chk("t4_held_evt", {24'h0, evt_valid, evt_idx, evt_hex, evt_err}, {24'h0, 1'b1, 3'd0, 4'h1, 1'b0});
    drive(7'h79, 4'b0100, 6);
    drive(7'h33, 4'b1000, 6);
    chk("t4_held_evt_end", {24'h0, evt_valid, evt_idx, evt_hex, evt_err}, {24'h0, 1'b1, 3'd0, 4'h1, 1'b0});
    chk("t4_overrun", {31'h0, overrun}, 32'h1);
    chk("t4_digits", {16'h0, digits}, 32'h4321);
    chk("t4_dig_vld", {28'h0, dig_vld}, 32'hF);
    @(negedge clk);
    ovr_clr = 1'b1;
    @(posedge clk);
    #1 chk("t4_ovr_clr", {31'h0, overrun}, 32'h0);
    @(negedge clk);
    ovr_clr = 1'b0;
    evt_ready = 1'b1;
    drive(7'h00, 4'b0000, 3);
    chk("t4_events", exp_q.size(), 0);

    // 5: handshake coinciding with a new commit
    @(negedge clk);
    evt_ready = 1'b0;
    expect_evt(3'd1, 4'h5, 1'b0);
    drive(7'h5B, 4'b0010, 6);
    expect_evt(3'd3, 4'h6, 1'b0);
    @(negedge clk);
    seg = 7'h5F;
    dig_sel = 4'b1000;
    repeat (4) @(posedge clk);
    @(negedge clk);
    evt_ready = 1'b1;
    @(posedge clk);
    #1 chk("t5_back_to_back", {24'h0, evt_valid, evt_idx, evt_hex, overrun},
           {24'h0, 1'b1, 3'd3, 4'h6, 1'b0});
    drive(7'h00, 4'b0000, 3);
    chk("t5_events", exp_q.size(), 0);

    // 6: reset with an event pending and mid-track
    @(negedge clk);
    evt_ready = 1'b0;
    drive(7'h7F, 4'b0010, 6);
    chk("t6_pending", {31'h0, evt_valid}, 32'h1);
    @(negedge clk);
    seg = 7'h70;
    dig_sel = 4'b0001;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("t6_async_reset", {8'h0, evt_valid, evt_idx, evt_hex, evt_err, digits, dig_vld, overrun},
           32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    expect_evt(3'd0, 4'h7, 1'b0);
    repeat (4) @(posedge clk);
    #1 chk("t6_relock_early", {31'h0, evt_valid}, 32'h0);
    @(posedge clk);
    #1 chk("t6_relock", {31'h0, evt_valid}, 32'h1);
    drive(7'h00, 4'b0000, 3);
    chk("t6_digits", {16'h0, digits}, 32'h0007);
    chk("t6_dig_vld", {28'h0, dig_vld}, 32'h1);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
